// File: rtl/mem_stage_pkg.sv
// Shared types for the memory/write-back stage: FSM state encoding,
// timeout default, write-back select codes and the registered WB bundle.
package mem_stage_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int          CNT_W           = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  wr_reg;
    logic        reg_write;
    logic        halt;
    logic        createdump;
    logic        err;
  } wb_bundle_t;

  // Link wins over a load so jal-style instructions always return PC+2.
  function automatic wb_sel_t wb_select(input logic link, input logic mem_to_reg);
    if (link)       return WB_SEL_LINK;
    if (mem_to_reg) return WB_SEL_MEM;
    return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/dff.sv
// Plain D flip-flop cell; callers apply any clearing on d.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/mem_ctrl_fsm.sv
// Memory access controller: issues one-cycle requests, waits for done,
// abandons the access after TIMEOUT busy cycles, and drives the stall.
module mem_ctrl_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        access,
  input  logic        misaligned,
  input  logic        halted,
  input  logic        store,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mem_done,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        stall_out,
  output logic        done_hit,
  output logic        timeout_hit
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  mem_state_t       state_reg, state_next;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_d, cnt_inc;
  logic             req, stall;

  dff #(.W(1))     u_state (.clk(clk), .d(state_d), .q(state_q));
  dff #(.W(CNT_W)) u_cnt   (.clk(clk), .d(cnt_d),   .q(cnt_reg));

  assign state_reg = mem_state_t'(state_q);
  assign state_d   = rst ? state_next : IDLE;
  assign cnt_d     = rst ? cnt_next   : '0;
  assign cnt_inc   = (cnt_reg >= TMO) ? TMO : cnt_reg + CNT_W'(1);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    req         = 1'b0;
    stall       = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (access && !misaligned && !halted) begin
          req        = 1'b1;
          stall      = 1'b1;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Done is checked first so it beats a timeout in the same cycle.
        if (mem_done) begin
          done_hit   = 1'b1;
          state_next = IDLE;
        end else if (cnt_inc >= TMO) begin
          timeout_hit = 1'b1;
          cnt_next    = TMO;
          state_next  = IDLE;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req   = req & rst;
  assign mem_wr    = req & rst & store;
  assign mem_addr  = (req && rst) ? addr  : 16'h0000;
  assign mem_wdata = (req && rst) ? wdata : 16'h0000;
  assign stall_out = stall & rst;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: drives the data-memory handshake through mem_ctrl_fsm, selects
// the write-back value and registers the bundle for WB.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] XOut_in,
  input  logic [15:0] read2Data_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        halt_in,
  input  logic        createdump_in,
  input  logic        link_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic        err_in,
  input  logic [15:0] PC_plus_two_in,
  input  logic [2:0]  Write_register_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic        stall_out,
  output logic [15:0] WB_data_out,
  output logic [2:0]  Write_register_out,
  output logic        RegWrite_out,
  output logic        halt_out,
  output logic        createdump_out,
  output logic        err_out
);

  wb_bundle_t wb_next, wb_d, wb_reg;
  logic [0:0] halted_d, halted_q;
  logic       halted_reg;
  logic       access, misaligned, capture, force_err;
  logic       done_hit, timeout_hit;

  assign access     = MemRead_in | MemWrite_in;
  assign misaligned = access & XOut_in[0];

  mem_ctrl_fsm #(.TIMEOUT(TIMEOUT)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .access     (access),
    .misaligned (misaligned),
    .halted     (halted_reg),
    .store      (MemWrite_in),
    .addr       (XOut_in),
    .wdata      (read2Data_in),
    .mem_done   (mem_done),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stall_out  (stall_out),
    .done_hit   (done_hit),
    .timeout_hit(timeout_hit)
  );

  // Misaligned is only ever seen in IDLE; BUSY is entered with aligned inputs held.
  assign capture   = !stall_out && !halted_reg;
  assign force_err = misaligned | timeout_hit;

  always_comb begin
    wb_next = '0;
    if (capture) begin
      unique case (wb_select(link_in, MemtoReg_in))
        WB_SEL_LINK: wb_next.data = PC_plus_two_in;
        WB_SEL_MEM:  wb_next.data = mem_rdata;
        default:     wb_next.data = XOut_in;
      endcase
      wb_next.wr_reg     = Write_register_in;
      wb_next.reg_write  = RegWrite_in & ~force_err;
      wb_next.halt       = halt_in;
      wb_next.createdump = createdump_in;
      wb_next.err        = err_in | (done_hit & mem_err) | force_err;
    end
  end

  assign wb_d     = rst ? wb_next : '0;
  assign halted_d = rst ? (halted_reg | wb_next.halt) : 1'b0;

  dff #(.W($bits(wb_bundle_t))) u_wb     (.clk(clk), .d(wb_d),     .q(wb_reg));
  dff #(.W(1))                  u_halted (.clk(clk), .d(halted_d), .q(halted_q));

  assign halted_reg         = halted_q[0];
  assign WB_data_out        = wb_reg.data;
  assign Write_register_out = wb_reg.wr_reg;
  assign RegWrite_out       = wb_reg.reg_write;
  assign halt_out           = wb_reg.halt;
  assign createdump_out     = wb_reg.createdump;
  assign err_out            = wb_reg.err;

endmodule
